// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock edge monitor: FSM state encoding and
// synchronizer depth limit.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_LOCKED  = 2'b10,
      ST_STALLED = 2'b11
   } mon_state_t;

   localparam int unsigned MAX_SYNC_STAGES = 4;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk_in
// domain; every stage resets to 0.
module sync_ff
   import clk_mon_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d,
   output logic q
);

   // Depth is kept inside the supported window so a bad override cannot
   // produce a zero-width or oversized chain.
   localparam int unsigned N = (STAGES < 2) ? 2 :
                               ((STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : STAGES);

   logic [N-1:0] sync_r;

   // Shift chain, input enters at bit 0.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[N-2:0], d};
      end
   end

   assign q = sync_r[N-1];

endmodule

// File: rtl/clk_edge_monitor.sv
// Measures period and high time of a slow asynchronous signal in clk_in
// cycles and flags when its rising edges stop arriving.
module clk_edge_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned TIMEOUT     = 1000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 sig_in,
   output logic                 rise_pulse,
   output logic                 fall_pulse,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic                 period_valid,
   output logic                 stalled
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   logic                 sync_s;
   logic                 hist_r;
   logic                 rise_r;
   logic                 fall_r;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic [CNT_WIDTH-1:0] high_r;
   logic [CNT_WIDTH-1:0] period_r;
   logic [CNT_WIDTH-1:0] high_time_r;
   logic                 valid_r;
   logic                 stalled_r;
   logic                 timeout_s;
   mon_state_t           state_r;
   mon_state_t           state_s;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d      (sig_in),
      .q      (sync_s)
   );

   // Edge detection; hist_r is the pulse-aligned level of the monitored signal.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hist_r <= 1'b0;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         hist_r <= sync_s;
         rise_r <= sync_s & ~hist_r;
         fall_r <= ~sync_s & hist_r;
      end
   end

   // Cycle and high-level counters restart on each rising edge; the high
   // count starts at 1 because the rise cycle itself is a high cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_r  <= '0;
         high_r <= '0;
      end else if (rise_r) begin
         cnt_r  <= '0;
         high_r <= CNT_ONE;
      end else begin
         cnt_r  <= sat_inc(cnt_r);
         high_r <= hist_r ? sat_inc(high_r) : high_r;
      end
   end

   // Capture a measurement only when a previous rise opened the window.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         period_r    <= '0;
         high_time_r <= '0;
      end else if (rise_r && ((state_r == ST_ARMED) || (state_r == ST_LOCKED))) begin
         period_r    <= sat_inc(cnt_r);
         high_time_r <= high_r;
      end else begin
         period_r    <= period_r;
         high_time_r <= high_time_r;
      end
   end

   assign timeout_s = (cnt_r == TIMEOUT_C);

   // Next-state logic; a rise always takes priority over the timeout.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rise_r)         state_s = ST_ARMED;
            else if (timeout_s) state_s = ST_STALLED;
            else                state_s = ST_IDLE;
         end
         ST_ARMED: begin
            if (rise_r)         state_s = ST_LOCKED;
            else if (timeout_s) state_s = ST_STALLED;
            else                state_s = ST_ARMED;
         end
         ST_LOCKED: begin
            if (rise_r)         state_s = ST_LOCKED;
            else if (timeout_s) state_s = ST_STALLED;
            else                state_s = ST_LOCKED;
         end
         ST_STALLED: begin
            if (rise_r) state_s = ST_ARMED;
            else        state_s = ST_STALLED;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register with status flags registered from the next state.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r   <= ST_IDLE;
         valid_r   <= 1'b0;
         stalled_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         valid_r   <= (state_s == ST_LOCKED);
         stalled_r <= (state_s == ST_STALLED);
      end
   end

   assign rise_pulse   = rise_r;
   assign fall_pulse   = fall_r;
   assign period       = period_r;
   assign high_time    = high_time_r;
   assign period_valid = valid_r;
   assign stalled      = stalled_r;

endmodule
